writeback_m1: RTL and testbench

Writeback stage of the M1 core, directly downstream of the execute-stage ALU. Merges the ALU's single-cycle results (no backpressure) with results from the memory/load unit (valid/ready handshake, buffered in a small FIFO) onto the single register-file write port. Provides a registered forwarding tap and an issue-hold request that prevents the load path from being starved by back-to-back ALU traffic.

---
 rtl/m1_wb_pkg.sv | 19 +
 rtl/wb_fifo_m1.sv | 58 +++++
 rtl/writeback_m1.sv | 106 ++++++++++
 tb/tb_writeback_m1.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m1_wb_pkg.sv
// Shared types and constants for the M1 writeback stage.
package m1_wb_pkg;

  localparam int M1_RF_ADDR_W = 4;
  localparam int M1_DATA_W    = 16;

  typedef struct packed {
    logic [M1_RF_ADDR_W-1:0] addr;
    logic [M1_DATA_W-1:0]    data;
  } wb_entry_t;

  localparam logic [3:0] STARVE_SAT = 4'd15;

  // Saturating increment for the 4-bit starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == STARVE_SAT) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/wb_fifo_m1.sv
// Load-result FIFO for the M1 writeback stage: pointers carry one wrap bit,
// occupancy is tracked separately in a count register.
module wb_fifo_m1
  import m1_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_entry_t         mem_q [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr[AW-1:0]];

  // Storage is not reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + CW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + CW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_m1.sv
// M1 writeback stage: merges ALU results and buffered load results onto the
// register-file write port. Optional forwarding tap under M1_WB_FWD_EN.
module writeback_m1
  import m1_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [M1_RF_ADDR_W-1:0] alu_dest,
  input  logic [M1_DATA_W-1:0]    alu_data,
  input  logic                    mem_valid,
  input  logic [M1_RF_ADDR_W-1:0] mem_dest,
  input  logic [M1_DATA_W-1:0]    mem_data,
  output logic                    mem_ready,
  output logic                    rf_we,
  output logic [M1_RF_ADDR_W-1:0] rf_waddr,
  output logic [M1_DATA_W-1:0]    rf_wdata,
  output logic                    fwd_valid,
  output logic [M1_RF_ADDR_W-1:0] fwd_addr,
  output logic [M1_DATA_W-1:0]    fwd_data,
  output logic                    issue_hold
);

  localparam logic [3:0] LIM_C = 4'(STARVE_LIM);

  wb_entry_t  push_entry;
  wb_entry_t  head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_next;

  // Load handshake: a transfer happens on a cycle with mem_valid && mem_ready.
  // mem_ready depends only on reset and occupancy, never on mem_valid or a
  // same-cycle pop, so the source may hold its offer until accepted.
  assign mem_ready  = !rst && !fifo_full;
  assign push_entry = '{addr: mem_dest, data: mem_data};
  assign pop        = !alu_valid && !fifo_empty;

  wb_fifo_m1 #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (mem_valid && mem_ready),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

  // ALU has absolute priority; it has no backpressure path.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (alu_valid) begin
      rf_we    <= 1'b1;
      rf_waddr <= alu_dest;
      rf_wdata <= alu_data;
    end else if (!fifo_empty) begin
      rf_we    <= 1'b1;
      rf_waddr <= head.addr;
      rf_wdata <= head.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (fifo_empty || pop) begin
      starve_cnt_next = '0;
    end else if (alu_valid) begin
      starve_cnt_next = sat_inc(starve_cnt);
    end
  end

  // issue_hold tracks the counter's next value so it rises together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      issue_hold <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      issue_hold <= (starve_cnt_next >= LIM_C);
    end
  end

`ifdef M1_WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_addr  = rf_waddr;
  assign fwd_data  = rf_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_m1.sv
// Bench for writeback_m1: directed literal checks plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_writeback_m1;

  localparam int DEPTH = 4;
  localparam int LIM   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_dest = '0;
  logic [15:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic [15:0] mem_data = '0;
  logic        mem_ready;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic        issue_hold;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  writeback_m1 #(
    .FIFO_DEPTH (DEPTH),
    .STARVE_LIM (LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_dest   (alu_dest),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_dest   (mem_dest),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .issue_hold (issue_hold)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [19:0] exp_q[$];
  logic        m_we = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_hold = 1'b0;
  logic        m_acc = 1'b0;
  logic        started = 1'b0;
  int          losses = 0;

  always @(posedge clk) begin
    bit had;
    bit rdy;
    logic [19:0] e;
    started = 1'b1;
    m_acc   = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0;
      losses = 0;
      m_hold = 1'b0;
    end else begin
      had = exp_q.size() > 0;
      rdy = exp_q.size() < DEPTH;
      if (alu_valid) begin
        m_we = 1'b1; m_addr = alu_dest; m_data = alu_data;
        losses = had ? ((losses < 15) ? losses + 1 : 15) : 0;
      end else if (had) begin
        e = exp_q.pop_front();
        m_we = 1'b1; m_addr = e[19:16]; m_data = e[15:0];
        losses = 0;
      end else begin
        m_we = 1'b0;
        losses = 0;
      end
      if (mem_valid && rdy) begin
        exp_q.push_back({mem_dest, mem_data});
        m_acc = 1'b1;
      end
      m_hold = (losses >= LIM);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      check("rf_we", 32'(rf_we), 32'(m_we));
      check("rf_waddr", 32'(rf_waddr), 32'(m_addr));
      check("rf_wdata", 32'(rf_wdata), 32'(m_data));
      check("issue_hold", 32'(issue_hold), 32'(m_hold));
      check("mem_ready", 32'(mem_ready), 32'(!rst && exp_q.size() < DEPTH));
`ifdef M1_WB_FWD_EN
      check("fwd_valid", 32'(fwd_valid), 32'(m_we));
      check("fwd_addr", 32'(fwd_addr), 32'(m_addr));
      check("fwd_data", 32'(fwd_data), 32'(m_data));
`else
      check("fwd_valid", 32'(fwd_valid), 32'd0);
      check("fwd_addr", 32'(fwd_addr), 32'd0);
      check("fwd_data", 32'(fwd_data), 32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [3:0] a, input logic [15:0] d);
    alu_valid = v; alu_dest = a; alu_data = d;
  endtask

  task automatic set_mem(input logic v, input logic [3:0] a, input logic [15:0] d);
    mem_valid = v; mem_dest = a; mem_data = d;
  endtask

  task automatic check_wr(input string name, input logic we, input logic [3:0] a, input logic [15:0] d);
    check({name, ".we"}, 32'(rf_we), 32'(we));
    check({name, ".addr"}, 32'(rf_waddr), 32'(a));
    check({name, ".data"}, 32'(rf_wdata), 32'(d));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bias;
    // Reset state
    step(); step();
    check_wr("reset", 1'b0, 4'd0, 16'h0000);
    check("reset.hold", 32'(issue_hold), 32'd0);
    check("reset.ready_in_rst", 32'(mem_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("reset.ready", 32'(mem_ready), 32'd1);
    step();

    // ALU only
    set_alu(1'b1, 4'd3, 16'h1234);
    step();
    check_wr("alu", 1'b1, 4'd3, 16'h1234);
`ifdef M1_WB_FWD_EN
    check("alu.fwd", 32'({fwd_valid, fwd_addr, fwd_data}), {11'd0, 1'b1, 4'd3, 16'h1234});
`else
    check("alu.fwd", 32'({fwd_valid, fwd_addr, fwd_data}), 32'd0);
`endif
    set_alu(1'b0, 4'd0, 16'h0);
    step();
    check_wr("alu_idle", 1'b0, 4'd3, 16'h1234);

    // Load only: two cycles of latency through the FIFO
    set_mem(1'b1, 4'd7, 16'hBEEF);
    step();
    check("load.n1_we", 32'(rf_we), 32'd0);
    set_mem(1'b0, 4'd0, 16'h0);
    step();
    check_wr("load", 1'b1, 4'd7, 16'hBEEF);
    step();
    check("load.done_we", 32'(rf_we), 32'd0);

    // Fill under ALU pressure; starvation raises issue_hold
    for (int i = 1; i <= 4; i++) begin
      set_alu(1'b1, 4'(8 + i), 16'(16'hC000 + i));
      set_mem(1'b1, 4'(i), 16'(16'hA000 + i));
      step();
    end
    check("full.ready", 32'(mem_ready), 32'd0);
    check("starve.hold", 32'(issue_hold), 32'd1);
    check_wr("full.alu4", 1'b1, 4'd12, 16'hC004);
    set_alu(1'b0, 4'd0, 16'h0);
    set_mem(1'b1, 4'd5, 16'hA005);
    step();
    check_wr("drain1", 1'b1, 4'd1, 16'hA001);
    check("drain1.hold", 32'(issue_hold), 32'd0);
    step();
    check_wr("drain2", 1'b1, 4'd2, 16'hA002);
    set_mem(1'b0, 4'd0, 16'h0);
    for (int i = 3; i <= 5; i++) begin
      step();
      check_wr("drain", 1'b1, 4'(i), 16'(16'hA000 + i));
    end
    step();
    check("drain.empty_we", 32'(rf_we), 32'd0);

    // Collision on the same destination
    set_mem(1'b1, 4'd5, 16'h0002);
    step();
    set_mem(1'b0, 4'd0, 16'h0);
    set_alu(1'b1, 4'd5, 16'h0001);
    step();
    check_wr("coll.alu", 1'b1, 4'd5, 16'h0001);
    set_alu(1'b0, 4'd0, 16'h0);
    step();
    check_wr("coll.load", 1'b1, 4'd5, 16'h0002);
    step();

    // Reset mid-drain
    for (int i = 0; i < 2; i++) begin
      set_alu(1'b1, 4'd1, 16'h1111);
      set_mem(1'b1, 4'(14 + i), 16'(16'hD000 + i));
      step();
    end
    set_alu(1'b0, 4'd0, 16'h0);
    set_mem(1'b0, 4'd0, 16'h0);
    rst = 1'b1;
    step();
    check_wr("rst_mid", 1'b0, 4'd0, 16'h0000);
    check("rst_mid.hold", 32'(issue_hold), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid.ready", 32'(mem_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid.no_stale", 32'(rf_we), 32'd0);
    end

    // Randomized traffic; the source holds an offer until accepted
    for (int c = 0; c < 3000; c++) begin
      if (m_acc) mem_valid = 1'b0;
      if (!mem_valid && $urandom_range(0, 9) < 6)
        set_mem(1'b1, 4'($urandom_range(0, 15)), 16'($urandom));
      bias = ((c / 400) % 2 == 1) ? 90 : 35;
      if (!m_hold && $urandom_range(0, 99) < bias)
        set_alu(1'b1, 4'($urandom_range(0, 15)), 16'($urandom));
      else
        set_alu(1'b0, 4'd0, 16'h0);
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
